pwm_duty_controller: RTL and testbench

- Sequences the duty-cycle setting of the 16-step PWM core.
- Arbitrates between two push-button requesters (increment/decrement) and a host register write port.
- Ramps the duty one step at a time, changing it only at PWM period boundaries so the waveform never sees a mid-period update.
- Drives the 4-bit duty input of the PWM core and emits one-cycle step-indication pulses.

---
 rtl/pwm_duty_controller_if.sv | 11 +
 rtl/pwm_duty_controller.sv | 149 ++++++++++++++
 tb/tb_pwm_duty_controller.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_controller_if.sv
// Host target-write handshake for the PWM duty controller.
interface pwm_duty_controller_if #(
    parameter int unsigned DUTY_W = 4
);
    logic              host_valid;
    logic [DUTY_W-1:0] host_duty;
    logic              host_ready;

    modport master (output host_valid, output host_duty, input host_ready);
    modport slave  (input host_valid, input host_duty, output host_ready);
endinterface

// File: rtl/pwm_duty_controller.sv
// Duty-cycle sequencer for the 16-step PWM core: arbitrates buttons and host writes, then
// ramps duty_out one step per RAMP_DIV period boundaries.
module pwm_duty_controller #(
    parameter int unsigned DUTY_W          = 4,
    parameter int unsigned DUTY_RESET      = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RAMP_DIV        = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_inc,
    input  logic                   btn_dec,
    input  logic                   period_start,
    pwm_duty_controller_if.slave   host,
    output logic [DUTY_W-1:0]      duty_out,
    output logic                   inc_pulse,
    output logic                   dec_pulse,
    output logic                   busy
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned STEP_W = $clog2(RAMP_DIV + 1);
    localparam logic [DUTY_W-1:0] DutyMax  = '1;
    localparam logic [DUTY_W-1:0] DutyInit = DUTY_W'(DUTY_RESET);

    typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

    // Bit 0 is the increment button, bit 1 the decrement button.
    logic [1:0]      btn_raw;
    logic [1:0]      btn_meta;
    logic [1:0]      btn_sync;
    logic [1:0]      level;
    logic [1:0]      level_prev;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;

    state_e            state;
    logic [DUTY_W-1:0] target;
    logic [STEP_W-1:0] step_cnt;
    logic              step_due;
    logic [DUTY_W-1:0] duty_up;
    logic [DUTY_W-1:0] duty_dn;

    assign btn_raw = {btn_dec, btn_inc};
    assign press   = level & ~level_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            level      <= '0;
            level_prev <= '0;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            btn_meta   <= btn_raw;
            btn_sync   <= btn_meta;
            level_prev <= level;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync[i] != level[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= btn_sync[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        step_due = period_start && (step_cnt == STEP_W'(RAMP_DIV - 1));
        duty_up  = duty_out + DUTY_W'(1);
        duty_dn  = duty_out - DUTY_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            duty_out        <= DutyInit;
            target          <= DutyInit;
            step_cnt        <= '0;
            inc_pulse       <= 1'b0;
            dec_pulse       <= 1'b0;
            busy            <= 1'b0;
            host.host_ready <= 1'b1;
        end else begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (host.host_valid && host.host_ready) begin
                        target   <= host.host_duty;
                        step_cnt <= '0;
                        if (host.host_duty > duty_out) begin
                            state           <= StRampUp;
                            busy            <= 1'b1;
                            host.host_ready <= 1'b0;
                        end else if (host.host_duty < duty_out) begin
                            state           <= StRampDown;
                            busy            <= 1'b1;
                            host.host_ready <= 1'b0;
                        end
                    end else if (press == 2'b11) begin
                        // Conflicting presses cancel each other.
                    end else if (press[0] && duty_out != DutyMax) begin
                        target          <= duty_up;
                        step_cnt        <= '0;
                        state           <= StRampUp;
                        busy            <= 1'b1;
                        host.host_ready <= 1'b0;
                    end else if (press[1] && duty_out != '0) begin
                        target          <= duty_dn;
                        step_cnt        <= '0;
                        state           <= StRampDown;
                        busy            <= 1'b1;
                        host.host_ready <= 1'b0;
                    end
                end
                StRampUp, StRampDown: begin
                    if (step_due) begin
                        step_cnt <= '0;
                        if (state == StRampUp) begin
                            duty_out  <= duty_up;
                            inc_pulse <= 1'b1;
                        end else begin
                            duty_out  <= duty_dn;
                            dec_pulse <= 1'b1;
                        end
                        if ((state == StRampUp ? duty_up : duty_dn) == target) begin
                            state           <= StIdle;
                            busy            <= 1'b0;
                            host.host_ready <= 1'b1;
                        end
                    end else if (period_start) begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
                default: begin
                    state           <= StIdle;
                    busy            <= 1'b0;
                    host.host_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_duty_controller.sv
// Directed and randomized check of pwm_duty_controller against a per-cycle behavioural model.
module tb_pwm_duty_controller;
    localparam int unsigned DUTY_W = 4;
    localparam int DRST = 5;
    localparam int DEB  = 4;
    localparam int RDIV = 2;
    localparam int MAXD = 15;

    logic              clk;
    logic              rst_n;
    logic              btn_inc;
    logic              btn_dec;
    logic              period_start;
    logic [DUTY_W-1:0] duty_out;
    logic              inc_pulse;
    logic              dec_pulse;
    logic              busy;

    pwm_duty_controller_if #(.DUTY_W(DUTY_W)) hif ();

    pwm_duty_controller #(
        .DUTY_W(DUTY_W),
        .DUTY_RESET(DRST),
        .DEBOUNCE_CYCLES(DEB),
        .RAMP_DIV(RDIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .period_start(period_start),
        .host(hif.slave),
        .duty_out(duty_out),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int gcyc  = 0;
    int n_inc = 0;
    int n_dec = 0;

    // Reference model state: ramping is simply "duty differs from target".
    int       m_duty, m_target, m_per;
    bit       m_inc, m_dec;
    bit [1:0] m_meta, m_sync, m_lvl, m_prev;
    int       m_run [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, gcyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_duty = DRST; m_target = DRST; m_per = 0;
        m_inc = 0; m_dec = 0;
        m_meta = '0; m_sync = '0; m_lvl = '0; m_prev = '0;
        m_run[0] = 0; m_run[1] = 0;
    endtask

    task automatic model_step();
        bit [1:0] press;
        press = m_lvl & ~m_prev;
        m_inc = 0;
        m_dec = 0;
        if (m_duty == m_target) begin
            if (hif.host_valid) begin
                m_target = int'(hif.host_duty);
                m_per = 0;
            end else if (press == 2'b11) begin
                m_per = m_per;
            end else if (press[0] && m_duty < MAXD) begin
                m_target = m_duty + 1;
                m_per = 0;
            end else if (press[1] && m_duty > 0) begin
                m_target = m_duty - 1;
                m_per = 0;
            end
        end else if (period_start) begin
            m_per++;
            if (m_per == RDIV) begin
                m_per = 0;
                if (m_target > m_duty) begin
                    m_duty++; m_inc = 1;
                end else begin
                    m_duty--; m_dec = 1;
                end
            end
        end
        m_prev = m_lvl;
        for (int i = 0; i < 2; i++) begin
            if (m_sync[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = m_sync[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_sync = m_meta;
        m_meta = {btn_dec, btn_inc};
    endtask

    task automatic check_all();
        chk("duty_out", 32'(duty_out), 32'(m_duty));
        chk("busy", 32'(busy), 32'(m_duty != m_target));
        chk("host_ready", 32'(hif.host_ready), 32'(m_duty == m_target));
        chk("inc_pulse", 32'(inc_pulse), 32'(m_inc));
        chk("dec_pulse", 32'(dec_pulse), 32'(m_dec));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        gcyc++;
        check_all();
        if (inc_pulse) n_inc++;
        if (dec_pulse) n_dec++;
    endtask

    task automatic run_ps(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            period_start = (gcyc % per == per - 1);
            tick();
        end
        period_start = 1'b0;
    endtask

    task automatic wait_idle(input int per);
        for (int i = 0; i < 300 && m_duty != m_target; i++) begin
            period_start = (gcyc % per == per - 1);
            tick();
        end
        period_start = 1'b0;
        chk("ramp_done", 32'(busy), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        btn_inc = 1'b0; btn_dec = 1'b0; period_start = 1'b0;
        hif.host_valid = 1'b0; hif.host_duty = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        check_all();
    endtask

    task automatic host_write(input int d);
        hif.host_valid = 1'b1;
        hif.host_duty  = DUTY_W'(d);
        tick();
        hif.host_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        apply_reset();

        // Idle after reset: periodic period_start changes nothing.
        n_inc = 0; n_dec = 0;
        run_ps(40, 16);
        chk("idle_duty", 32'(duty_out), 32'd5);
        chk("idle_pulses", 32'(n_inc + n_dec), 32'd0);

        // Host ramp 5 -> 8.
        n_inc = 0;
        host_write(8);
        chk("ready_after_accept", 32'(hif.host_ready), 32'd0);
        wait_idle(4);
        chk("ramp8_duty", 32'(duty_out), 32'd8);
        chk("ramp8_incs", 32'(n_inc), 32'd3);
        chk("ramp8_ready", 32'(hif.host_ready), 32'd1);

        // Bouncy decrement press from reset value.
        apply_reset();
        n_dec = 0;
        for (int i = 0; i < 6; i++) begin
            btn_dec = ~btn_dec;
            tick();
        end
        btn_dec = 1'b1;
        run_ps(10, 4);
        btn_dec = 1'b0;
        run_ps(30, 4);
        chk("bounce_duty", 32'(duty_out), 32'd4);
        chk("bounce_decs", 32'(n_dec), 32'd1);

        // Glitch shorter than the debounce window.
        n_dec = 0;
        btn_dec = 1'b1;
        run_ps(3, 4);
        btn_dec = 1'b0;
        run_ps(30, 4);
        chk("glitch_duty", 32'(duty_out), 32'd4);
        chk("glitch_decs", 32'(n_dec), 32'd0);

        // Saturation at both ends.
        host_write(15);
        wait_idle(2);
        n_inc = 0;
        btn_inc = 1'b1;
        run_ps(10, 2);
        btn_inc = 1'b0;
        run_ps(20, 2);
        chk("max_duty", 32'(duty_out), 32'd15);
        chk("max_incs", 32'(n_inc), 32'd0);
        host_write(0);
        wait_idle(2);
        n_dec = 0;
        btn_dec = 1'b1;
        run_ps(10, 2);
        btn_dec = 1'b0;
        run_ps(20, 2);
        chk("min_duty", 32'(duty_out), 32'd0);
        chk("min_decs", 32'(n_dec), 32'd0);
        n_inc = 0;
        host_write(15);
        wait_idle(2);
        chk("full_ramp_duty", 32'(duty_out), 32'd15);
        chk("full_ramp_incs", 32'(n_inc), 32'd15);

        // Host write wins over a same-cycle increment press.
        apply_reset();
        n_inc = 0; n_dec = 0;
        btn_inc = 1'b1;
        for (int i = 0; i < 20 && !(m_lvl[0] && !m_prev[0]); i++) tick();
        chk("press_seen", 32'(m_lvl[0] && !m_prev[0]), 32'd1);
        host_write(3);
        btn_inc = 1'b0;
        wait_idle(4);
        run_ps(12, 4);
        chk("host_prio_duty", 32'(duty_out), 32'd3);
        chk("host_prio_incs", 32'(n_inc), 32'd0);
        chk("host_prio_decs", 32'(n_dec), 32'd2);

        // Simultaneous inc and dec presses cancel.
        n_inc = 0; n_dec = 0;
        btn_inc = 1'b1; btn_dec = 1'b1;
        run_ps(10, 4);
        btn_inc = 1'b0; btn_dec = 1'b0;
        run_ps(20, 4);
        chk("both_duty", 32'(duty_out), 32'd3);
        chk("both_pulses", 32'(n_inc + n_dec), 32'd0);

        // Reset mid-ramp at 7 heading to 10.
        apply_reset();
        host_write(10);
        for (int i = 0; i < 100 && m_duty != 7; i++) begin
            period_start = (gcyc % 4 == 3);
            tick();
        end
        period_start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_duty", 32'(duty_out), 32'd5);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(hif.host_ready), 32'd1);
        chk("rst_pulse", 32'({inc_pulse, dec_pulse}), 32'd0);
        apply_reset();
        n_inc = 0; n_dec = 0;
        run_ps(20, 2);
        chk("post_rst_duty", 32'(duty_out), 32'd5);
        chk("post_rst_pulses", 32'(n_inc + n_dec), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 19) == 0) btn_dec = ~btn_dec;
            period_start   = ($urandom_range(0, 5) == 0);
            hif.host_valid = ($urandom_range(0, 15) == 0);
            hif.host_duty  = DUTY_W'($urandom_range(0, MAXD));
            tick();
        end
        hif.host_valid = 1'b0;
        period_start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
